// File: rtl/exe_stage.sv
// exe_stage: execute stage of a 5-stage pipeline.
//   Forwards operands A/B and store data from the ID/EX register, the EX/MEM
//   ALU result or the write-back value, evaluates a single-cycle ALU op and
//   registers the result with the pass-through fields. MUL runs as a 32-cycle
//   shift-add on a small FSM and holds the pipeline with stall meanwhile.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   EXE_CMD[3:0]                      ALU operation
//   val1, val2, ST_value [31:0]       ID/EX operands and store data
//   dest[4:0], MEM_R_EN, MEM_W_EN, WB_EN   pass-through destination/controls
//   sel_src1, sel_src2, sel_st [1:0]  forward selects (00 ID/EX, 01 MEM, 10 WB)
//   mem_fwd_val, wb_fwd_val [31:0]    forwarded values
//   flush                             squash the current instruction
//   ALU_result, ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
//                                     registered EX/MEM outputs
//   stall                             combinational, high while a MUL occupies the stage
//
// state | meaning
// IDLE  | normal issue; a MUL here latches operands and starts the multiply
// BUSY  | one shift-add step per cycle, 32 cycles
// DONE  | product ready; written to the outputs at the next edge
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] ST_value,
  input  logic [4:0]  dest,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [1:0]  sel_st,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  input  logic        flush,
  output logic [31:0] ALU_result,
  output logic [31:0] ST_val_out,
  output logic [4:0]  dest_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        WB_EN_out,
  output logic        stall
);

  localparam logic [3:0] CMD_MOV = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0011;
  localparam logic [3:0] CMD_OR  = 4'b0100;
  localparam logic [3:0] CMD_NOR = 4'b0101;
  localparam logic [3:0] CMD_XOR = 4'b0110;
  localparam logic [3:0] CMD_SLL = 4'b0111;
  localparam logic [3:0] CMD_SRL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SLT = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic        mul_start;

  logic [31:0] op_a, op_b, st_fwd;
  logic [31:0] alu_res;

  logic [31:0] mul_acc;
  logic [31:0] mul_mcand;
  logic [31:0] mul_mplier;
  logic [31:0] mul_st;
  logic [4:0]  mul_dest;
  logic [2:0]  mul_ctrl;   // {MEM_R_EN, MEM_W_EN, WB_EN}
  logic [4:0]  cnt;

  // Forward muxes; 11 falls back to the ID/EX value.
  always_comb begin
    op_a = val1;
    case (sel_src1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = val1;
    endcase
    op_b = val2;
    case (sel_src2)
      2'b01:   op_b = mem_fwd_val;
      2'b10:   op_b = wb_fwd_val;
      default: op_b = val2;
    endcase
    st_fwd = ST_value;
    case (sel_st)
      2'b01:   st_fwd = mem_fwd_val;
      2'b10:   st_fwd = wb_fwd_val;
      default: st_fwd = ST_value;
    endcase
  end

  // Single-cycle ALU; MUL and the unused codes produce 0 here.
  always_comb begin
    alu_res = '0;
    case (EXE_CMD)
      CMD_MOV: alu_res = op_b;
      CMD_ADD: alu_res = op_a + op_b;
      CMD_SUB: alu_res = op_a - op_b;
      CMD_AND: alu_res = op_a & op_b;
      CMD_OR:  alu_res = op_a | op_b;
      CMD_NOR: alu_res = ~(op_a | op_b);
      CMD_XOR: alu_res = op_a ^ op_b;
      CMD_SLL: alu_res = op_a << op_b[4:0];
      CMD_SRL: alu_res = op_a >> op_b[4:0];
      CMD_SRA: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      CMD_SLT: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // Next state and stall. DONE always returns to IDLE so the MUL still
  // sitting in ID/EX during DONE is consumed rather than restarted.
  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    mul_start = 1'b0;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (EXE_CMD == CMD_MUL) begin
            stall     = 1'b1;
            mul_start = 1'b1;
            state_nx  = BUSY;
          end
        end
        BUSY: begin
          stall = 1'b1;
          if (cnt == 5'd31) state_nx = DONE;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_result   <= '0;
      ST_val_out   <= '0;
      dest_out     <= '0;
      MEM_R_EN_out <= 1'b0;
      MEM_W_EN_out <= 1'b0;
      WB_EN_out    <= 1'b0;
      mul_acc      <= '0;
      mul_mcand    <= '0;
      mul_mplier   <= '0;
      mul_st       <= '0;
      mul_dest     <= '0;
      mul_ctrl     <= '0;
      cnt          <= '0;
    end else if (flush) begin
      ALU_result   <= '0;
      ST_val_out   <= '0;
      dest_out     <= '0;
      MEM_R_EN_out <= 1'b0;
      MEM_W_EN_out <= 1'b0;
      WB_EN_out    <= 1'b0;
    end else if (stall) begin
      ALU_result   <= '0;
      ST_val_out   <= '0;
      dest_out     <= '0;
      MEM_R_EN_out <= 1'b0;
      MEM_W_EN_out <= 1'b0;
      WB_EN_out    <= 1'b0;
      if (mul_start) begin
        mul_acc    <= '0;
        mul_mcand  <= op_a;
        mul_mplier <= op_b;
        mul_st     <= st_fwd;
        mul_dest   <= dest;
        mul_ctrl   <= {MEM_R_EN, MEM_W_EN, WB_EN};
        cnt        <= '0;
      end else begin
        // LSB-first shift-add; only the low 32 bits of the product are kept.
        mul_acc    <= mul_acc + (mul_mplier[0] ? mul_mcand : 32'd0);
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        cnt        <= cnt + 5'd1;
      end
    end else if (state == DONE) begin
      ALU_result   <= mul_acc;
      ST_val_out   <= mul_st;
      dest_out     <= mul_dest;
      MEM_R_EN_out <= mul_ctrl[2];
      MEM_W_EN_out <= mul_ctrl[1];
      WB_EN_out    <= mul_ctrl[0];
    end else begin
      ALU_result   <= alu_res;
      ST_val_out   <= st_fwd;
      dest_out     <= dest;
      MEM_R_EN_out <= MEM_R_EN;
      MEM_W_EN_out <= MEM_W_EN;
      WB_EN_out    <= WB_EN;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1, val2, ST_value;
  logic [4:0]  dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN;
  logic [1:0]  sel_src1, sel_src2, sel_st;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic        flush;
  logic [31:0] ALU_result, ST_val_out;
  logic [4:0]  dest_out;
  logic        MEM_R_EN_out, MEM_W_EN_out, WB_EN_out;
  logic        stall;

  int errors = 0;
  int checks = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2),
    .ST_value(ST_value), .dest(dest), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .WB_EN(WB_EN), .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_st(sel_st),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .flush(flush),
    .ALU_result(ALU_result), .ST_val_out(ST_val_out), .dest_out(dest_out),
    .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .WB_EN_out(WB_EN_out), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic wb);
    EXE_CMD = cmd; val1 = a; val2 = b; WB_EN = wb;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ST_value = 32'd0; dest = 5'd1;
    sel_src1 = 2'b00; sel_src2 = 2'b00; sel_st = 2'b00;
    #1;
  endtask

  // Runs out a multiply already presented; returns stall cycles and whether
  // any stalled cycle produced a non-bubble. Scrambles inputs mid-way, which
  // the stage must ignore after the latch cycle.
  task automatic wait_mul(output int n, output bit bad);
    n = 0;
    bad = 1'b0;
    for (int i = 0; i < 60 && stall; i++) begin
      n++;
      step();
      if ({ALU_result, ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out} !== '0)
        bad = 1'b1;
      if (n == 5) begin
        val1 = 32'h1234_5678; val2 = 32'h0000_0077; ST_value = 32'hAAAA_0000;
        mem_fwd_val = 32'h0BAD_0BAD; wb_fwd_val = 32'h0F0F_0F0F; dest = 5'd31;
        MEM_R_EN = 1'b1;
      end
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    set_op(4'b0001, 32'd9, 32'd9, 1'b1);
    mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
    step(); step();
    checks++;
    if ({ALU_result, ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out} !== '0) begin
      errors++; $display("FAIL reset_outputs got alu=%h wb=%b exp all zero", ALU_result, WB_EN_out);
    end
    rst = 1'b0;
    set_op(4'b0001, 32'd0, 32'd0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_add();
    set_op(4'b0001, 32'd5, 32'd7, 1'b1);
    dest = 5'd3; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", stall); end
    step();
    checks++;
    if (ALU_result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp %h", ALU_result, 32'd12); end
    checks++;
    if ({WB_EN_out, dest_out} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL add_ctrl got wb=%b dest=%0d exp wb=1 dest=3", WB_EN_out, dest_out);
    end
  endtask

  task automatic test_forward();
    set_op(4'b0010, 32'd0, 32'd30, 1'b1);
    sel_src1 = 2'b01; mem_fwd_val = 32'd100; #1;
    step();
    checks++;
    if (ALU_result !== 32'd70) begin errors++; $display("FAIL fwd_mem got %h exp %h", ALU_result, 32'd70); end
    set_op(4'b0010, 32'd0, 32'd30, 1'b1);
    sel_src2 = 2'b10; wb_fwd_val = 32'hFFFF_FFFF; #1;
    step();
    checks++;
    if (ALU_result !== 32'd1) begin errors++; $display("FAIL fwd_wb got %h exp %h", ALU_result, 32'd1); end
    set_op(4'b0010, 32'd9, 32'd4, 1'b1);
    sel_src1 = 2'b11; sel_src2 = 2'b11; ST_value = 32'h11;
    sel_st = 2'b01; mem_fwd_val = 32'hCAFE_0001; #1;
    step();
    checks++;
    if (ALU_result !== 32'd5) begin errors++; $display("FAIL fwd_sel11 got %h exp %h", ALU_result, 32'd5); end
    checks++;
    if (ST_val_out !== 32'hCAFE_0001) begin errors++; $display("FAIL fwd_store got %h exp %h", ST_val_out, 32'hCAFE_0001); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  cmd [14];
    logic [31:0] a   [14];
    logic [31:0] b   [14];
    logic [31:0] exp [14];
    cmd[0]  = 4'b0000; a[0]  = 32'h1;         b[0]  = 32'hDEAD_BEEF; exp[0]  = 32'hDEAD_BEEF;
    cmd[1]  = 4'b0001; a[1]  = 32'hFFFF_FFFF; b[1]  = 32'h1;         exp[1]  = 32'h0;
    cmd[2]  = 4'b0010; a[2]  = 32'd3;         b[2]  = 32'd5;         exp[2]  = 32'hFFFF_FFFE;
    cmd[3]  = 4'b0011; a[3]  = 32'hFF00_FF00; b[3]  = 32'h0FF0_0FF0; exp[3]  = 32'h0F00_0F00;
    cmd[4]  = 4'b0100; a[4]  = 32'hFF00_FF00; b[4]  = 32'h0FF0_0FF0; exp[4]  = 32'hFFF0_FFF0;
    cmd[5]  = 4'b0101; a[5]  = 32'hF0F0_F0F0; b[5]  = 32'h0F0F_0000; exp[5]  = 32'h0000_0F0F;
    cmd[6]  = 4'b0110; a[6]  = 32'hFF00_FF00; b[6]  = 32'h0FF0_0FF0; exp[6]  = 32'hF0F0_F0F0;
    cmd[7]  = 4'b0111; a[7]  = 32'h1;         b[7]  = 32'd4;         exp[7]  = 32'h10;
    cmd[8]  = 4'b0111; a[8]  = 32'h1234_5678; b[8]  = 32'h20;        exp[8]  = 32'h1234_5678;
    cmd[9]  = 4'b1000; a[9]  = 32'h8000_0000; b[9]  = 32'd4;         exp[9]  = 32'h0800_0000;
    cmd[10] = 4'b1001; a[10] = 32'h8000_0000; b[10] = 32'd31;        exp[10] = 32'hFFFF_FFFF;
    cmd[11] = 4'b1010; a[11] = 32'hFFFF_FFFF; b[11] = 32'd1;         exp[11] = 32'd1;
    cmd[12] = 4'b1010; a[12] = 32'd1;         b[12] = 32'hFFFF_FFFF; exp[12] = 32'd0;
    cmd[13] = 4'b1111; a[13] = 32'h5;         b[13] = 32'h6;         exp[13] = 32'd0;
    for (int i = 0; i < 14; i++) begin
      set_op(cmd[i], a[i], b[i], 1'b1);
      step();
      checks++;
      if (ALU_result !== exp[i]) begin
        errors++; $display("FAIL alu_op%0d cmd=%b got %h exp %h", i, cmd[i], ALU_result, exp[i]);
      end
    end
  endtask

  task automatic test_mul();
    int n; bit bad;
    set_op(4'b1011, 32'hFFFF_FFFF, 32'd3, 1'b1);
    MEM_W_EN = 1'b1; ST_value = 32'h55; dest = 5'd7; #1;
    wait_mul(n, bad);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL mul_stall_len got %0d exp 33", n); end
    checks++;
    if (bad) begin errors++; $display("FAIL mul_bubbles got non-bubble exp all zero"); end
    step();
    checks++;
    if (ALU_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_result got %h exp %h", ALU_result, 32'hFFFF_FFFD); end
    checks++;
    if ({ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out} !== {32'h55, 5'd7, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mul_ctrl got st=%h dest=%0d r/w/wb=%b%b%b exp st=55 dest=7 r/w/wb=011",
                         ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out);
    end
    set_op(4'b0001, 32'd20, 32'd22, 1'b1);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mul_no_restart got %b exp 0", stall); end
    step();
    checks++;
    if (ALU_result !== 32'd42) begin errors++; $display("FAIL mul_after_add got %h exp %h", ALU_result, 32'd42); end
  endtask

  task automatic test_back_to_back();
    int n; bit bad;
    set_op(4'b1011, 32'd6, 32'd7, 1'b1);
    wait_mul(n, bad);
    step();
    checks++;
    if (ALU_result !== 32'd42) begin errors++; $display("FAIL b2b_first got %h exp %h", ALU_result, 32'd42); end
    set_op(4'b1011, 32'd2, 32'd5, 1'b1);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b2b_start got %b exp 1", stall); end
    wait_mul(n, bad);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL b2b_stall_len got %0d exp 33", n); end
    step();
    checks++;
    if (ALU_result !== 32'd10) begin errors++; $display("FAIL b2b_second got %h exp %h", ALU_result, 32'd10); end
  endtask

  task automatic test_flush();
    set_op(4'b0001, 32'd3, 32'd4, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({ALU_result, WB_EN_out} !== {32'd0, 1'b0}) begin
      errors++; $display("FAIL flush_add got alu=%h wb=%b exp 0/0", ALU_result, WB_EN_out);
    end
    set_op(4'b1011, 32'd6, 32'd7, 1'b1);
    for (int i = 0; i < 11; i++) step();   // now BUSY with cnt=10
    flush = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_forced got %b exp 0", stall); end
    step();
    flush = 1'b0;
    set_op(4'b0001, 32'd1, 32'd1, 1'b1);
    checks++;
    if ({ALU_result, WB_EN_out, stall} !== {32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_mul got alu=%h wb=%b stall=%b exp 0/0/0", ALU_result, WB_EN_out, stall);
    end
    step();
    checks++;
    if ({ALU_result, WB_EN_out} !== {32'd2, 1'b1}) begin
      errors++; $display("FAIL flush_then_add got alu=%h wb=%b exp 2/1", ALU_result, WB_EN_out);
    end
  endtask

  task automatic test_rst_mid_mul();
    int n; bit bad; bit wrote;
    set_op(4'b1011, 32'd6, 32'd7, 1'b1);
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(4'b1100, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({ALU_result, ST_val_out, dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, stall} !== '0) begin
      errors++; $display("FAIL rst_mid_mul got alu=%h wb=%b stall=%b exp all zero", ALU_result, WB_EN_out, stall);
    end
    wrote = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ALU_result !== 32'd0 || WB_EN_out !== 1'b0) wrote = 1'b1;
    end
    checks++;
    if (wrote) begin errors++; $display("FAIL rst_abort got product written exp none"); end
    set_op(4'b1011, 32'd2, 32'd3, 1'b1);
    wait_mul(n, bad);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL rst_fresh_stall got %0d exp 33", n); end
    step();
    checks++;
    if (ALU_result !== 32'd6) begin errors++; $display("FAIL rst_fresh_mul got %h exp %h", ALU_result, 32'd6); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_flush();
    test_rst_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  clock (all state on posedge); rst  in  1  synchronous active-high reset.
REQ-002 SHALL have the following inputs from the ID/EX register:
- EXE_CMD  in  4  ALU operation
- val1, val2  in  32 each  operands
- ST_value  in  32  store data
- dest  in  5  destination register
- MEM_R_EN, MEM_W_EN, WB_EN  in  1 each  control bits
REQ-003 SHALL have the following inputs from the hazard/forwarding unit:
- sel_src1, sel_src2, sel_st  in  2 each  forward select
- mem_fwd_val  in  32  EX/MEM ALU result
- wb_fwd_val  in  32  write-back value
- flush  in  1  squash the current instruction
REQ-004 SHALL have the following outputs, all registered:
- ALU_result  out  32
- ST_val_out  out  32
- dest_out  out  5
- MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1 each
REQ-005 SHALL have output stall  out  1, combinational, asserted while a multiply is in progress.

Function
REQ-006 Forward mux (operand A from sel_src1, operand B from sel_src2, store data from sel_st):
- 00 selects ID/EX value (val1, val2, ST_value).
- 01 selects mem_fwd_val.
- 10 selects wb_fwd_val.
- 11 behaves as 00.
REQ-007 EXE_CMD encoding (A, B are the forwarded operands):
- 0000 MOV=B; 0001 ADD; 0010 SUB (A-B); 0011 AND; 0100 OR; 0101 NOR; 0110 XOR.
- 0111 SLL; 1000 SRL; 1001 SRA: A shifted by B[4:0].
- 1010 SLT: signed A<B gives 1, else 0.
- 1011 MUL: multi-cycle.
- 1100-1111: result 0.
REQ-008 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow trap; MUL result SHALL be the low 32 bits of the product (equal for signed and unsigned).
REQ-009 Non-MUL commands SHALL have 1-cycle latency: at each posedge, without stall or flush, outputs load the result, forwarded store data, dest and the three control bits.
REQ-010 The MUL FSM SHALL have states IDLE, BUSY and DONE.
REQ-011 In IDLE with EXE_CMD=1011 and flush=0:
- stall=1 combinationally.
- At the posedge, latch forwarded A, B, store data, dest and control bits; clear the accumulator; set the 5-bit counter cnt=0; go to BUSY.
REQ-012 In BUSY:
- stall=1.
- Each cycle, shift-add one multiplier bit (LSB first).
- cnt increments; when cnt=31 the next state is DONE.
- This gives 32 BUSY cycles.
REQ-013 In DONE:
- stall=0.
- At the posedge, outputs load the product and the latched store data, dest and controls; go to IDLE.
REQ-014 MUL timing: with MUL presented in cycle 0, stall is high in cycles 0-32 (33 cycles), the FSM is in DONE in cycle 33, and the result is visible at the outputs in cycle 34.
REQ-015 While stall=1, the output register SHALL load a bubble each cycle: MEM_R_EN_out=MEM_W_EN_out=WB_EN_out=0, with data fields 0.
REQ-016 While stall=1, upstream holds its inputs constant; the block SHALL ignore input and forward-value changes after the latch cycle.
REQ-017 The DONE cycle SHALL consume the MUL held in ID/EX; the block SHALL NOT restart a multiply in DONE even though EXE_CMD still reads 1011.
REQ-018 flush=1 (any state, rst=0):
- Outputs load a bubble at the next posedge.
- The FSM goes to IDLE.
- Any multiply in progress is discarded.
- stall is forced to 0 in that cycle.
REQ-019 Priority SHALL be rst > flush > stall/MUL > normal issue.
REQ-020 A MUL entering IDLE in the cycle directly after DONE SHALL start a new multiply normally (back-to-back MULs).

Reset
REQ-021 When rst=1 at a posedge, the block SHALL set all outputs to 0, FSM=IDLE, cnt=0 and the accumulator/latched operands to 0.
REQ-022 stall SHALL be 0 while the FSM is IDLE after reset, until a MUL is presented with rst=0.
REQ-023 Asserting rst mid-multiply SHALL abort it; no product is ever written.

Verification
REQ-024 ADD: val1=5, val2=7, WB_EN=1, sel=00 -> next cycle ALU_result=12, WB_EN_out=1, stall never 1.
REQ-025 Forwarding: SUB, sel_src1=01, mem_fwd_val=100, val2=30; then sel_src2=10, wb_fwd_val=-1 with val1=0 -> 70, then 1.
REQ-026 MUL: A=0xFFFF_FFFF, B=3 -> stall high exactly 33 cycles, bubbles during that time, then ALU_result=0xFFFF_FFFD with controls restored.
REQ-027 flush at BUSY cnt=10 during MUL 6*7 -> next cycle bubble, stall=0, FSM IDLE; a following ADD 1+1 yields 2 one cycle later.
REQ-028 rst asserted at cycle 20 of a MUL -> all outputs 0, stall 0; a fresh MUL 2*3 afterwards yields 6 with the full 33-cycle stall.
REQ-029 Shift/SLT edges: SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; SLL by 32 (B=0x20) -> unchanged A; SLT -1,1 -> 1.
